// File: rtl/stopwatch_fnd_ctrl_if.sv
// Time-field and FND display bundle between the stopwatch counters and the scan controller.
interface stopwatch_fnd_ctrl_if;
  logic [6:0] i_msec;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic       i_mode;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_data;

  // Time source side: drives the fields, observes the display lines.
  modport master (
    output i_msec, i_sec, i_min, i_hour, i_mode,
    input  o_fnd_com, o_fnd_data
  );

  // Display controller side.
  modport slave (
    input  i_msec, i_sec, i_min, i_hour, i_mode,
    output o_fnd_com, o_fnd_data
  );
endinterface

// File: rtl/stopwatch_fnd_ctrl.sv
// Four-digit common-anode FND scan controller with per-frame snapshot and 1 Hz blinking dp.
module stopwatch_fnd_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input logic                  clk,
  input logic                  rst,
  stopwatch_fnd_ctrl_if.slave  bus
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef struct packed {
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       mode;
  } time_snap_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  time_snap_t       snap_q, snap_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       data_q, data_d;

  logic             tick;
  logic             frame_start;
  time_snap_t       live;
  time_snap_t       src;
  logic [6:0]       low;
  logic [5:0]       high;
  logic [3:0]       digit;
  logic             dp_on;

  // Segment pattern for one BCD nibble, active-low {dp,g,f,e,d,c,b,a}, dp off.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Next-state: scan divider, digit index, snapshot capture and segment/enable load.
  always_comb begin
    live.msec = bus.i_msec;
    live.sec  = bus.i_sec;
    live.min  = bus.i_min;
    live.hour = bus.i_hour;
    live.mode = bus.i_mode;

    tick        = (cnt_q == CNT_W'(DIV - 1));
    frame_start = tick && (idx_q == 2'd3);

    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    snap_d = frame_start ? live : snap_q;

    // Digit 0 of a new frame reads the live fields, which are exactly what the snapshot captures.
    src  = frame_start ? live : snap_q;
    low  = src.mode ? {1'b0, src.min} : src.msec;
    high = src.mode ? {1'b0, src.hour} : src.sec;

    case (idx_d)
      2'd0:    digit = 4'(low % 7'd10);
      2'd1:    digit = 4'((low / 7'd10) % 7'd10);
      2'd2:    digit = 4'(high % 6'd10);
      default: digit = 4'((high / 6'd10) % 6'd10);
    endcase

    dp_on = (idx_d == 2'd2) && (src.msec < 7'd50);

    com_d  = com_q;
    data_d = data_q;
    if (tick) begin
      com_d  = ~(4'b0001 << idx_d);
      data_d = seg_code(digit) & {~dp_on, 7'h7F};
    end
  end

  // State registers; reset blanks the display and parks the index so the first tick selects digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 2'd3;
      snap_q <= '0;
      com_q  <= 4'b1111;
      data_q <= 8'hFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      com_q  <= com_d;
      data_q <= data_d;
    end
  end

  assign bus.o_fnd_com  = com_q;
  assign bus.o_fnd_data = data_q;

endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// Randomized self-checking bench for stopwatch_fnd_ctrl against a frame-level display model.
module tb_stopwatch_fnd_ctrl;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned SCAN_HZ = 100;
  localparam int          DIV     = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stopwatch_fnd_ctrl_if bus ();

  stopwatch_fnd_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Live inputs and model state.
  int v_msec, v_sec, v_min, v_hour, v_mode;
  int s_msec, s_sec, s_min, s_hour, s_mode;
  int n;
  int m_idx;
  logic [3:0] exp_com;
  logic [7:0] exp_data;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic int digit_of(input int idx, input int ms, input int s,
                                  input int mi, input int h, input int md);
    int lo, hi;
    lo = md ? mi : ms;
    hi = md ? h : s;
    case (idx)
      0:       return lo % 10;
      1:       return (lo / 10) % 10;
      2:       return hi % 10;
      default: return (hi / 10) % 10;
    endcase
  endfunction

  task automatic set_in(input int ms, input int s, input int mi, input int h, input int md);
    v_msec = ms; v_sec = s; v_min = mi; v_hour = h; v_mode = md;
    bus.i_msec = 7'(ms);
    bus.i_sec  = 6'(s);
    bus.i_min  = 6'(mi);
    bus.i_hour = 5'(h);
    bus.i_mode = 1'(md);
  endtask

  task automatic set_random();
    set_in(int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 1)));
  endtask

  // Advance one clock; the model derives the displayed digit from edges elapsed since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (n >= DIV) begin
      m_idx = ((n / DIV) - 1) % 4;
      if ((n % DIV) == 0 && m_idx == 0) begin
        s_msec = v_msec; s_sec = v_sec; s_min = v_min; s_hour = v_hour; s_mode = v_mode;
      end
      exp_com  = ~(4'b0001 << m_idx);
      exp_data = seg_tab[digit_of(m_idx, s_msec, s_sec, s_min, s_hour, s_mode)];
      if (m_idx == 2 && s_msec < 50) exp_data[7] = 1'b0;
    end else begin
      m_idx    = 3;
      exp_com  = 4'hF;
      exp_data = 8'hFF;
    end
  endtask

  // Step until the model sits on the edge where a new frame's digit 0 appears.
  task automatic sync_frame();
    for (int i = 0; i < 6 * DIV; i++) begin
      step();
      if (n >= DIV && (n % DIV) == 0 && m_idx == 0) return;
    end
    compared++;
    mismatched++;
    $display("FAIL sync_frame: no frame start within %0d cycles", 6 * DIV);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_random();
    #23;
    compared++;
    if (bus.o_fnd_com !== 4'hF || bus.o_fnd_data !== 8'hFF) begin
      mismatched++;
      $display("FAIL reset_hold: com=%b data=%h required com=1111 data=ff", bus.o_fnd_com, bus.o_fnd_data);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    n   = 0;
    for (int k = 1; k <= DIV; k++) begin
      step();
      compared++;
      if (bus.o_fnd_com !== exp_com || bus.o_fnd_data !== exp_data) begin
        mismatched++;
        $display("FAIL reset_release edge %0d: com=%b data=%h required com=%b data=%h",
                 k, bus.o_fnd_com, bus.o_fnd_data, exp_com, exp_data);
      end
    end
    compared++;
    if (bus.o_fnd_com !== 4'b1110) begin
      mismatched++;
      $display("FAIL first_tick_com: com=%b required 1110", bus.o_fnd_com);
    end
  endtask

  // Runs a full frame from a frame start, checking the model every cycle and fixed codes per digit.
  task automatic check_frame(input string name, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] want;
    for (int k = 0; k < 4 * DIV; k++) begin
      if (k > 0) step();
      case (k / DIV)
        0:       want = c0;
        1:       want = c1;
        2:       want = c2;
        default: want = c3;
      endcase
      compared++;
      if (bus.o_fnd_com !== exp_com || bus.o_fnd_data !== exp_data) begin
        mismatched++;
        $display("FAIL %s model k=%0d: com=%b data=%h required com=%b data=%h",
                 name, k, bus.o_fnd_com, bus.o_fnd_data, exp_com, exp_data);
      end
      compared++;
      if (bus.o_fnd_data !== want || bus.o_fnd_com !== ~(4'b0001 << (k / DIV))) begin
        mismatched++;
        $display("FAIL %s const k=%0d: com=%b data=%h required data=%h", name, k,
                 bus.o_fnd_com, bus.o_fnd_data, want);
      end
    end
  endtask

  task automatic test_scan_order();
    set_in(56, 34, 0, 0, 0);
    sync_frame();
    check_frame("scan_order", 8'h82, 8'h92, 8'h99, 8'hB0);
    step();
    check_frame("scan_repeat", 8'h82, 8'h92, 8'h99, 8'hB0);
  endtask

  task automatic test_decimal_point();
    set_in(12, 7, 0, 0, 0);
    sync_frame();
    check_frame("decimal_point", 8'hA4, 8'hF9, 8'h78, 8'hC0);
  endtask

  task automatic test_mode1();
    set_in(70, 0, 5, 23, 1);
    sync_frame();
    check_frame("mode1", 8'h92, 8'hC0, 8'hB0, 8'hA4);
    set_in(30, 0, 5, 23, 1);
    sync_frame();
    check_frame("mode1_dp", 8'h92, 8'hC0, 8'h30, 8'hA4);
  endtask

  task automatic test_snapshot();
    set_in(60, 19, 0, 0, 0);
    sync_frame();
    for (int k = 0; k < 8 * DIV; k++) begin
      if (k > 0) step();
      if (k == DIV + 3) set_in(60, 20, 0, 0, 0);
      compared++;
      if (bus.o_fnd_com !== exp_com || bus.o_fnd_data !== exp_data) begin
        mismatched++;
        $display("FAIL snapshot model k=%0d: com=%b data=%h required com=%b data=%h",
                 k, bus.o_fnd_com, bus.o_fnd_data, exp_com, exp_data);
      end
      if (k == 2 * DIV + 1 || k == 3 * DIV + 1 || k == 6 * DIV + 1 || k == 7 * DIV + 1) begin
        logic [7:0] want;
        case (k)
          2 * DIV + 1: want = 8'h90;
          3 * DIV + 1: want = 8'hF9;
          6 * DIV + 1: want = 8'hC0;
          default:     want = 8'hA4;
        endcase
        compared++;
        if (bus.o_fnd_data !== want) begin
          mismatched++;
          $display("FAIL snapshot const k=%0d: data=%h required %h", k, bus.o_fnd_data, want);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    set_random();
    sync_frame();
    for (int k = 0; k < 2 * DIV; k++) step();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (bus.o_fnd_com !== 4'hF || bus.o_fnd_data !== 8'hFF) begin
      mismatched++;
      $display("FAIL mid_reset_blank: com=%b data=%h required com=1111 data=ff",
               bus.o_fnd_com, bus.o_fnd_data);
    end
    #2;
    rst = 1'b0;
    n   = 0;
    for (int k = 1; k <= DIV; k++) begin
      step();
      compared++;
      if (bus.o_fnd_com !== exp_com || bus.o_fnd_data !== exp_data) begin
        mismatched++;
        $display("FAIL mid_reset_restart edge %0d: com=%b data=%h required com=%b data=%h",
                 k, bus.o_fnd_com, bus.o_fnd_data, exp_com, exp_data);
      end
    end
    compared++;
    if (bus.o_fnd_com !== 4'b1110) begin
      mismatched++;
      $display("FAIL mid_reset_digit0: com=%b required 1110", bus.o_fnd_com);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      step();
      compared++;
      if (bus.o_fnd_com !== exp_com || bus.o_fnd_data !== exp_data) begin
        mismatched++;
        $display("FAIL random n=%0d: com=%b data=%h required com=%b data=%h",
                 n, bus.o_fnd_com, bus.o_fnd_data, exp_com, exp_data);
      end
      if ($urandom_range(0, 7) == 0) set_random();
    end
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n = 0;
    s_msec = 0; s_sec = 0; s_min = 0; s_hour = 0; s_mode = 0;
    m_idx = 3;
    exp_com = 4'hF;
    exp_data = 8'hFF;
    set_in(0, 0, 0, 0, 0);
    test_reset();
    test_scan_order();
    test_decimal_point();
    test_mode1();
    test_snapshot();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_fnd_ctrl.md
# stopwatch_fnd_ctrl

Four-digit, common-anode 7-segment (FND) scan controller that consumes the stopwatch time fields (msec, sec, min, hour) and drives the board display. Time-multiplexes one digit per scan period, splits the selected fields into BCD digits, blinks the centre decimal point at 1 Hz, and captures a coherent snapshot once per frame so no frame mixes old and new values. Sits directly downstream of the stopwatch time counters.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- SCAN_HZ, 1000, digit-advance rate in Hz; DIV = CLK_HZ/SCAN_HZ must be an integer ≥ 2
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- i_msec  input  7  centiseconds, 0..99
- i_sec  input  6  seconds, 0..59
- i_min  input  6  minutes, 0..59
- i_hour  input  5  hours, 0..23
- i_mode  input  1  0: display sec:msec; 1: display hour:min
- o_fnd_com  output  4  digit enables, active-low, bit0 = rightmost digit
- o_fnd_data  output  8  segments, active-low, order {dp,g,f,e,d,c,b,a}

## Operation
- Scan divider: counter 0..DIV-1, width $clog2(DIV); internal scan tick when count == DIV-1, then wraps to 0.
- Digit index: 2-bit register, advances on each scan tick, 3 → 0 wraps.
- Field select: low = i_mode ? min : msec; high = i_mode ? hour : sec.
- Digit map: d0 = low % 10, d1 = (low / 10) % 10, d2 = high % 10, d3 = (high / 10) % 10. Out-of-range inputs (e.g. msec > 99) are not saturated; the modulo rule above applies.
- Snapshot: on the scan tick where the index goes 3 → 0, msec/sec/min/hour/mode are captured into snapshot registers; digits 1–3 of that frame use the snapshot. Digit 0 is computed from the live inputs at that edge (identical to the values loaded into the snapshot).
- Decimal point: lit (bit7 = 0) only on digit 2, and only when snapshot msec < 50 (50 % duty, 1 Hz). In mode 1, dp follows the same rule.
- Segment codes (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex). Codes for nibbles 10–15 = FF (blank).
- o_fnd_com: exactly one bit low, at the position of the current index, once scanning has begun.

## Timing
- Reset values: divider 0, index 3, snapshot all 0, o_fnd_com = 4'b1111, o_fnd_data = 8'hFF (display blank).
- o_fnd_com and o_fnd_data are registered and load on the same clock edge as the index advance, using the new index; they are otherwise held.
- First scan tick after reset release: the edge at which divider == DIV-1, i.e. the DIV-th rising edge. On that edge the index moves 3 → 0, the snapshot loads, and digit 0 appears.
- Subsequent digits change every DIV cycles; a full frame is 4·DIV cycles; an input change is visible no later than the next frame start.
- Input changes mid-frame have no effect on digits 1–3 of the current frame.
- i_mode change mid-frame takes effect at the next frame start (it is snapshotted).
- rst asserted mid-frame: all outputs go blank immediately (asynchronous); scanning restarts as after power-up.
- No handshake: inputs are assumed synchronous to clk and stable per cycle.

## Test plan
- Reset: assert rst with arbitrary inputs -> o_fnd_com = 1111, o_fnd_data = FF; stays blank for the first DIV-1 edges after release (CLK_HZ=1000, SCAN_HZ=100, DIV=10).
- Scan order: i_mode=0, sec=34, msec=56 -> com sequence 1110, 1101, 1011, 0111 repeating every 10 cycles; data 82 ("6"), 92 ("5"), 99 ("4"), B0 ("3"); dp off since msec ≥ 50.
- Decimal point: sec=7, msec=12 -> digit 2 data = 78 ("7" with dp); digit 3 = C0; digit 1 = F9; digit 0 = A4.
- Mode 1: hour=23, min=5, i_mode=1 -> digits 0..3 = 92, C0, B0, A4 (dp rule applies to digit 2 via the snapshot msec).
- Snapshot coherence: change sec 19 → 20 while digit 1 is displayed -> digits 2/3 of that frame still show 9/1; next frame shows 0/2.
- Mid-frame reset: pulse rst while digit 2 is active -> outputs blank on the same cycle; the first digit 0 reappears DIV cycles after release.
